// File: rtl/apb_slave.sv
// APB register slave: NREGS x 32-bit read/write registers at byte address 4*i, registered PRDATA/PREADY/PSLVERR.
// Define APB_SLAVE_WAIT_EN to insert one wait state (IDLE->WAIT->ACCESS) before the transfer completes.
module apb_slave #(
    parameter int NREGS = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

`ifdef APB_SLAVE_WAIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1} state_t;
`endif

    state_t            r_state;
    state_t            w_nxt_state;

    logic [31:0]       r_regs [NREGS];
    logic [IDXW-1:0]   r_idx;
    logic              r_write;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic [31:0]       r_prdata;
    logic              r_pready;
    logic              r_pslverr;

    logic              w_setup;
    logic              w_addr_err;
    logic [IDXW-1:0]   w_idx;
    logic              w_capture;
    logic              w_commit;
    logic [31:0]       w_nxt_prdata;
    logic              w_nxt_pready;
    logic              w_nxt_pslverr;

    assign w_setup    = PSEL && !PENABLE;
    assign w_addr_err = (PADDR[1:0] != 2'b00) || (PADDR[31:2] >= 30'(NREGS));
    assign w_idx      = PADDR[IDXW+1:2];

    always_comb begin
        w_nxt_state   = r_state;
        w_capture     = 1'b0;
        w_commit      = 1'b0;
        w_nxt_prdata  = r_prdata;
        w_nxt_pready  = r_pready;
        w_nxt_pslverr = r_pslverr;
        case (r_state)
            IDLE: begin
                w_nxt_prdata  = '0;
                w_nxt_pready  = 1'b0;
                w_nxt_pslverr = 1'b0;
                if (w_setup) begin
                    w_capture = 1'b1;
`ifdef APB_SLAVE_WAIT_EN
                    w_nxt_state = WAIT;
`else
                    w_nxt_state   = ACCESS;
                    w_nxt_pready  = 1'b1;
                    w_nxt_pslverr = w_addr_err;
                    w_nxt_prdata  = (!PWRITE && !w_addr_err) ? r_regs[w_idx] : '0;
`endif
                end
            end
`ifdef APB_SLAVE_WAIT_EN
            WAIT: begin
                if (!PSEL) begin
                    w_nxt_state = IDLE;
                end else begin
                    // Load is deferred to here so the read sees any state settled during the wait.
                    w_nxt_state   = ACCESS;
                    w_nxt_pready  = 1'b1;
                    w_nxt_pslverr = r_err;
                    w_nxt_prdata  = (!r_write && !r_err) ? r_regs[r_idx] : '0;
                end
            end
`endif
            ACCESS: begin
                if (!PSEL) begin
                    w_nxt_state   = IDLE;
                    w_nxt_prdata  = '0;
                    w_nxt_pready  = 1'b0;
                    w_nxt_pslverr = 1'b0;
                end else if (PENABLE) begin
                    w_commit      = r_write && !r_err;
                    w_nxt_state   = IDLE;
                    w_nxt_prdata  = '0;
                    w_nxt_pready  = 1'b0;
                    w_nxt_pslverr = 1'b0;
                end
            end
            default: begin
                w_nxt_state   = IDLE;
                w_nxt_prdata  = '0;
                w_nxt_pready  = 1'b0;
                w_nxt_pslverr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) r_state <= IDLE;
        else        r_state <= w_nxt_state;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            if (w_capture) begin
                r_idx   <= w_idx;
                r_write <= PWRITE;
                r_wdata <= PWDATA;
                r_err   <= w_addr_err;
            end
            if (w_commit) r_regs[r_idx] <= r_wdata;
            r_prdata  <= w_nxt_prdata;
            r_pready  <= w_nxt_pready;
            r_pslverr <= w_nxt_pslverr;
        end
    end

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: expected responses are queued at setup and checked in the access phase.
module tb_apb_slave;

    localparam int NREGS = 8;
`ifdef APB_SLAVE_WAIT_EN
    localparam int WAITS = 1;
`else
    localparam int WAITS = 0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    apb_slave #(.NREGS(NREGS)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [NREGS];
    int          checks = 0;
    int          passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    // One full transfer; leaves the bus at the cycle after completion so the caller can chain.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdat, input string tag);
        exp_t e;
        logic bad;
        int   n;
        bad   = (addr[1:0] != 2'b00) || (addr >= 32'(4 * NREGS));
        e.err = bad;
        e.rd  = (!wr && !bad) ? model[addr >> 2] : 32'h0;
        e.tag = tag;
        exp_q.push_back(e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdat;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        @(negedge PCLK);
        while (!PREADY && n < 4) begin
            n++;
            @(negedge PCLK);
        end
        e = exp_q.pop_front();
        check({e.tag, "_waits"}, 32'(n), 32'(WAITS));
        check({e.tag, "_ready"}, {31'h0, PREADY}, 32'h1);
        check({e.tag, "_err"}, {31'h0, PSLVERR}, {31'h0, e.err});
        check({e.tag, "_rdata"}, PRDATA, e.rd);
        @(posedge PCLK); #1;
        if (wr && !bad) model[addr >> 2] = wdat;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge PCLK);
        check({tag, "_ready"}, {31'h0, PREADY}, 32'h0);
        check({tag, "_err"}, {31'h0, PSLVERR}, 32'h0);
        check({tag, "_rdata"}, PRDATA, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0;
        repeat (2) @(posedge PCLK);
        #1;
        check_idle_outputs("reset");
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // PENABLE without a setup phase must be ignored.
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hFFFF_FFFF;
        @(posedge PCLK); #1;
        check_idle_outputs("no_setup");
        idle();

        xfer(1'b1, 32'h04, 32'hDEAD_BEEF, "w04");
        xfer(1'b0, 32'h04, 32'h0, "r04");
        idle();

        xfer(1'b1, 32'h00, 32'h11, "b2b_w00");
        xfer(1'b1, 32'h1C, 32'h22, "b2b_w1c");
        xfer(1'b0, 32'h00, 32'h0, "b2b_r00");
        xfer(1'b0, 32'h1C, 32'h0, "b2b_r1c");
        idle();

        xfer(1'b0, 32'h20, 32'h0, "err_r20");
        xfer(1'b1, 32'h20, 32'hBAD0_BAD0, "err_w20");
        xfer(1'b0, 32'h02, 32'h0, "err_r02");
        xfer(1'b1, 32'h06, 32'hCAFE_F00D, "err_w06");
        xfer(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, "err_whi");
        for (int i = 0; i < NREGS; i++) xfer(1'b0, 32'(4 * i), 32'h0, $sformatf("dump%0d", i));
        idle();

        xfer(1'b1, 32'h0C, 32'hA5A5_A5A5, "w0c");
        xfer(1'b0, 32'h0C, 32'h0, "r0c");
        idle();

        // Reset pulse in the access phase of a write to 0x08.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h55;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        check_idle_outputs("rst_mid");
        @(posedge PCLK); #1;
        xfer(1'b0, 32'h08, 32'h0, "rst_r08");
        xfer(1'b0, 32'h04, 32'h0, "rst_r04");
        idle();

        // PSEL dropped after setup of a write to 0x10.
        xfer(1'b1, 32'h10, 32'h1234_5678, "w10");
        idle();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h77;
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        @(posedge PCLK); #1;
        check_idle_outputs("abort");
        @(posedge PCLK); #1;
        xfer(1'b0, 32'h10, 32'h0, "abort_r10");
        xfer(1'b1, 32'h14, 32'h0BAD_CAFE, "abort_w14");
        xfer(1'b0, 32'h14, 32'h0, "abort_r14");
        idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
